// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch entry type for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned AW       = 8;
   localparam int unsigned DW       = 32;
   localparam logic [AW-1:0] RESET_PC = 8'd0;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO: power-of-two depth, flush clears occupancy, head reads as zero when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = fetch_entry_t,
   localparam int unsigned PW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   input  logic          flush,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   count,
   output entry_t        head
);

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]     count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, read strobe to the instruction bank, prefetch FIFO to decode.
module inst_fetch #(
   parameter int unsigned     AW       = fetch_pkg::AW,
   parameter int unsigned     DW       = fetch_pkg::DW,
   parameter int unsigned     DEPTH    = 2,
   parameter logic [AW-1:0]   RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_en,
   output logic          memread,
   output logic [AW-1:0] address,
   input  logic [DW-1:0] readdata,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic          inst_valid,
   output logic [DW-1:0] inst,
   output logic [AW-1:0] inst_pc,
   input  logic          inst_ready
);

   import fetch_pkg::*;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
   } entry_t;

   logic [AW-1:0]            pc_q, pc_d;
   logic                     pop, space;
   logic                     fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0]   fifo_count_unused;
   entry_t                   push_data, head;

   assign pop       = inst_valid & inst_ready;
   // A full FIFO still takes a fetch when decode frees the head in the same cycle.
   assign space     = ~fifo_full | pop;
   assign memread   = fetch_en & space & ~redirect;
   assign address   = pc_q;
   assign push_data = '{pc: pc_q, inst: readdata};

   always_comb begin
      pc_d = pc_q;
      if (redirect)     pc_d = redirect_pc;
      else if (memread) pc_d = pc_q + AW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (memread),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused),
      .head      (head)
   );

   assign inst_valid = ~fifo_empty;
   assign inst       = head.inst;
   assign inst_pc    = head.pc;

endmodule
